// File: rtl/multiplexed_keypad_scanner_if.sv
// rtl/multiplexed_keypad_scanner_if.sv - keypad matrix and key report signal bundle
interface multiplexed_keypad_scanner_if;
  logic [2:0] COL;
  logic [3:0] ROW;
  logic [3:0] KEY;
  logic       KEY_VALID;
  logic       KEY_DOWN;

  modport master (input COL, output ROW, KEY, KEY_VALID, KEY_DOWN);
  modport slave  (output COL, input ROW, KEY, KEY_VALID, KEY_DOWN);
endinterface

// File: rtl/multiplexed_keypad_scanner.sv
// rtl/multiplexed_keypad_scanner.sv - 4x3 keypad row scanner with whole-scan debounce
module multiplexed_keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  multiplexed_keypad_scanner_if.master  kif
);

  localparam logic [3:0]    NONE       = 4'hF;
  localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_MAX    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

  row_t          row_q, row_d;
  logic [PW-1:0] presc;
  logic [2:0]    col_s1, col_s2;
  logic          slot_end;
  logic [3:0]    row_hit, scan_acc, scan_result, prev_result;
  logic [3:0]    count, count_next, deb_state;
  logic [3:0]    key_q;
  logic          key_valid_q, key_down_q;

  // Leftmost low column wins within a row; row3 carries the * 0 # codes.
  function automatic logic [3:0] key_code(input row_t r, input logic [2:0] col_n);
    int c;
    logic [3:0] code;
    code = NONE;
    c = 0;
    if (!col_n[0])      c = 0;
    else if (!col_n[1]) c = 1;
    else if (!col_n[2]) c = 2;
    else                c = -1;
    if (c >= 0) begin
      if (r == ROW3) begin
        case (c)
          0:       code = 4'd10;
          1:       code = 4'd0;
          default: code = 4'd11;
        endcase
      end else begin
        code = 4'(int'(r) * 3 + c + 1);
      end
    end
    return code;
  endfunction

  assign slot_end    = (presc == PRESC_LAST);
  assign row_hit     = key_code(row_q, col_s2);
  assign scan_result = (scan_acc != NONE) ? scan_acc : row_hit;
  assign count_next  = (scan_result == prev_result)
                       ? ((count >= DEB_MAX) ? DEB_MAX : count + 4'd1)
                       : 4'd1;

  always_comb begin
    row_d = row_q;
    if (slot_end) begin
      case (row_q)
        ROW0:    row_d = ROW1;
        ROW1:    row_d = ROW2;
        ROW2:    row_d = ROW3;
        default: row_d = ROW0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) row_q <= ROW0;
    else          row_q <= row_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      presc       <= '0;
      col_s1      <= 3'b111;
      col_s2      <= 3'b111;
      scan_acc    <= NONE;
      prev_result <= NONE;
      count       <= 4'd0;
      deb_state   <= NONE;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      col_s1      <= kif.COL;
      col_s2      <= col_s1;
      key_valid_q <= 1'b0;
      presc       <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) begin
        if (row_q != ROW3) begin
          scan_acc <= scan_result;
        end else begin
          scan_acc    <= NONE;
          prev_result <= scan_result;
          count       <= count_next;
          if (count_next == DEB_MAX && scan_result != deb_state) begin
            deb_state <= scan_result;
            if (scan_result != NONE) begin
              key_q       <= scan_result;
              key_down_q  <= 1'b1;
              key_valid_q <= 1'b1;
            end else begin
              key_down_q  <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign kif.ROW       = ~(4'b0001 << row_q);
  assign kif.KEY       = key_q;
  assign kif.KEY_VALID = key_valid_q;
  assign kif.KEY_DOWN  = key_down_q;

endmodule

// File: tb/tb_multiplexed_keypad_scanner.sv
// tb/tb_multiplexed_keypad_scanner.sv - scoreboard bench for the keypad scanner
module tb_multiplexed_keypad_scanner;

  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [11:0] pressed = '0;
  logic [2:0]  col_model;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [3:0] exp_q[$];

  multiplexed_keypad_scanner_if kif();

  multiplexed_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .kif     (kif.master)
  );

  always #5 CLK = ~CLK;

  // Key at position r*3+c pulls COL[c] low only while its row is driven low.
  always_comb begin
    col_model = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !kif.ROW[r]) col_model[c] = 1'b0;
  end
  assign kif.COL = col_model;

  always @(negedge CLK) begin
    if (RESET_N && kif.KEY_VALID) begin
      logic [3:0] e;
      pulse_cnt = pulse_cnt + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse: KEY=%0d, no pulse expected", kif.KEY);
      end else begin
        e = exp_q.pop_front();
        if (kif.KEY !== e || kif.KEY_DOWN !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL pulse_key: KEY=%0d KEY_DOWN=%b, expected KEY=%0d KEY_DOWN=1",
                   kif.KEY, kif.KEY_DOWN, e);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_down(input logic level, input int max_clks, input string name);
    int n;
    n = 0;
    while (kif.KEY_DOWN !== level && n < max_clks) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (kif.KEY_DOWN !== level) begin
      errors++;
      $display("FAIL %s: KEY_DOWN=%b after %0d clocks, expected %b", name, kif.KEY_DOWN, n, level);
    end
  endtask

  task automatic check_pulses(input int got, input int want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: %0d pulses, expected %0d", name, got, want);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (kif.ROW !== 4'b1110 || kif.KEY !== 4'd0 || kif.KEY_VALID !== 1'b0 || kif.KEY_DOWN !== 1'b0) begin
      errors++;
      $display("FAIL %s: ROW=%b KEY=%0d KEY_VALID=%b KEY_DOWN=%b, expected 1110 0 0 0",
               name, kif.ROW, kif.KEY, kif.KEY_VALID, kif.KEY_DOWN);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_row;
    RESET_N = 1'b0;
    wait_clks(3);
    check_reset_outputs("reset_values");
    RESET_N = 1'b1;
    for (int k = 0; k < 2 * SCAN; k++) begin
      @(negedge CLK);
      exp_row = ~(4'b0001 << (((k + 1) / SD) % 4));
      checks++;
      if (kif.ROW !== exp_row) begin
        errors++;
        $display("FAIL row_seq: clk %0d ROW=%b, expected %b", k + 1, kif.ROW, exp_row);
      end
    end
  endtask

  task automatic test_clean_press;
    int base;
    base = pulse_cnt;
    exp_q.push_back(4'd5);
    pressed[4] = 1'b1;
    wait_down(1'b1, 4 * SCAN + 4, "press5_down");
    wait_clks(6 * SCAN);
    check_pulses(pulse_cnt - base, 1, "press5_pulses");
    pressed = '0;
    wait_down(1'b0, 4 * SCAN + 4, "release5_down");
    wait_clks(2 * SCAN);
    checks++;
    if (kif.KEY !== 4'd5) begin
      errors++;
      $display("FAIL key_hold: KEY=%0d, expected 5", kif.KEY);
    end
    check_pulses(pulse_cnt - base, 1, "release5_no_pulse");
    check_sb_empty("press5_sb");
  endtask

  task automatic test_bounce;
    int base;
    logic saw_down;
    base = pulse_cnt;
    saw_down = 1'b0;
    for (int s = 0; s < 8; s++) begin
      pressed[6] = (s % 2 == 0);
      for (int k = 0; k < SCAN; k++) begin
        @(negedge CLK);
        if (kif.KEY_DOWN) saw_down = 1'b1;
      end
    end
    pressed = '0;
    wait_clks(5 * SCAN);
    checks++;
    if (saw_down) begin
      errors++;
      $display("FAIL bounce_down: KEY_DOWN went 1, expected 0");
    end
    check_pulses(pulse_cnt - base, 0, "bounce_pulses");
  endtask

  task automatic test_code_map;
    int base;
    int pos[3] = '{9, 10, 11};
    logic [3:0] code[3] = '{4'd10, 4'd0, 4'd11};
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(code[i]);
      pressed[pos[i]] = 1'b1;
      wait_clks(5 * SCAN);
      pressed = '0;
      wait_clks(5 * SCAN);
    end
    check_pulses(pulse_cnt - base, 3, "codemap_pulses");
    check_sb_empty("codemap_sb");
  endtask

  task automatic test_multi_rollover;
    int base;
    logic dropped;
    base = pulse_cnt;
    dropped = 1'b0;
    exp_q.push_back(4'd1);
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    wait_down(1'b1, 4 * SCAN + 4, "multi_down");
    wait_clks(SCAN);
    check_pulses(pulse_cnt - base, 1, "multi_pulses");
    exp_q.push_back(4'd9);
    pressed[0] = 1'b0;
    for (int k = 0; k < 6 * SCAN; k++) begin
      @(negedge CLK);
      if (!kif.KEY_DOWN) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL rollover_down: KEY_DOWN dropped to 0, expected 1 throughout");
    end
    check_pulses(pulse_cnt - base, 2, "rollover_pulses");
    check_sb_empty("rollover_sb");
    pressed = '0;
    wait_down(1'b0, 4 * SCAN + 4, "rollover_release");
    wait_clks(2 * SCAN);
  endtask

  task automatic test_reset_mid_press;
    int base;
    int n;
    exp_q.push_back(4'd3);
    pressed[2] = 1'b1;
    wait_down(1'b1, 4 * SCAN + 4, "mid_press_down");
    wait_clks(3);
    check_sb_empty("mid_press_first_sb");
    RESET_N = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid_reset_values");
    RESET_N = 1'b1;
    base = pulse_cnt;
    exp_q.push_back(4'd3);
    n = 0;
    while (pulse_cnt == base && n < 4 * SCAN + 4) begin
      @(negedge CLK);
      n++;
    end
    check_pulses(pulse_cnt - base, 1, "mid_reset_fresh_pulse");
    check_sb_empty("mid_reset_sb");
    pressed = '0;
    wait_clks(5 * SCAN);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_code_map();
    test_multi_rollover();
    test_reset_mid_press();
    check_sb_empty("final_sb");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
